// File: rtl/instr_sequencer.sv
// instr_sequencer: program memory plus Run/DIN issue engine for the
// multicycle processor's control unit. Issues one word per instruction,
// supplies the mvi immediate during WAIT, advances PC on Done.
// Optional watchdog on WAIT compiled in with `define SEQ_WATCHDOG_EN.
module instr_sequencer #(
  parameter int unsigned IW        = 10,
  parameter int unsigned AW        = 5,
  parameter logic [2:0]  MVI_OP    = 3'b111,
  parameter int unsigned WD_CYCLES = 64
) (
  input  logic          clock,
  input  logic          Reset,
  input  logic          Start,
  input  logic [AW:0]   prog_len,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [IW-1:0] load_data,
  input  logic          Done,
  output logic          Run,
  output logic [IW-1:0] DIN,
  output logic [AW-1:0] PC,
  output logic          Busy,
  output logic          Halted,
  output logic          Err,
  output logic [15:0]   instr_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HALT
  } state_t;

  localparam logic [AW:0] PC_STEP1 = (AW+1)'(1);
  localparam logic [AW:0] PC_STEP2 = (AW+1)'(2);

  if (WD_CYCLES == 0) begin : g_wd_cfg_check
    $error("instr_sequencer: WD_CYCLES must be nonzero");
  end

  state_t        state_q, state_d;
  // PC carries one extra bit so the end-of-program compare sees PC+2 past 2^AW-1
  logic [AW:0]   pc_q, pc_d;
  logic [AW:0]   plen_q, plen_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          mvi_q, mvi_d;
  logic          halted_q, halted_d;

  logic [IW-1:0] mem_q [2**AW];
  logic          mem_we;

  logic [AW-1:0] pc_lo;
  logic [AW-1:0] imm_addr;
  logic [IW-1:0] cur_word;
  logic [AW:0]   pc_next;

`ifdef SEQ_WATCHDOG_EN
  localparam int unsigned    WDW     = (WD_CYCLES < 2) ? 1 : $clog2(WD_CYCLES);
  localparam logic [WDW-1:0] WD_LAST = WDW'(WD_CYCLES - 1);

  logic [WDW-1:0] wd_cnt_q, wd_cnt_d;
  logic           err_q, err_d;
`endif

  assign pc_lo    = pc_q[AW-1:0];
  assign imm_addr = pc_lo + 1'b1;
  assign cur_word = mem_q[pc_lo];
  assign pc_next  = pc_q + (mvi_q ? PC_STEP2 : PC_STEP1);

  // Program memory write port; only open while no program is executing
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[load_addr] <= load_data;
    end
  end

  // State and bookkeeping registers
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      plen_q   <= '0;
      cnt_q    <= '0;
      mvi_q    <= 1'b0;
      halted_q <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      plen_q   <= plen_d;
      cnt_q    <= cnt_d;
      mvi_q    <= mvi_d;
      halted_q <= halted_d;
`ifdef SEQ_WATCHDOG_EN
      wd_cnt_q <= wd_cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  // Next-state, datapath updates and issue-side outputs
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    plen_d   = plen_q;
    cnt_d    = cnt_q;
    mvi_d    = mvi_q;
    halted_d = halted_q;
    mem_we   = 1'b0;
    Run      = 1'b0;
    Busy     = 1'b0;
    DIN      = '0;
`ifdef SEQ_WATCHDOG_EN
    wd_cnt_d = wd_cnt_q;
    err_d    = err_q;
`endif

    unique case (state_q)
      S_IDLE, S_HALT: begin
        mem_we = load_en;
        if (Start) begin
`ifdef SEQ_WATCHDOG_EN
          err_d = 1'b0;
`endif
          if (prog_len != '0) begin
            plen_d   = prog_len;
            pc_d     = '0;
            cnt_d    = '0;
            halted_d = 1'b0;
            state_d  = S_ISSUE;
          end else begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end
        end
      end

      S_ISSUE: begin
        Run     = 1'b1;
        Busy    = 1'b1;
        DIN     = cur_word;
        mvi_d   = (cur_word[IW-1:IW-3] == MVI_OP);
        state_d = S_WAIT;
`ifdef SEQ_WATCHDOG_EN
        wd_cnt_d = '0;
`endif
      end

      S_WAIT: begin
        Busy = 1'b1;
        DIN  = mvi_q ? mem_q[imm_addr] : cur_word;
        if (Done) begin
          pc_d  = pc_next;
          cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
          if (pc_next >= plen_q) begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end else begin
            state_d  = S_ISSUE;
          end
        end
`ifdef SEQ_WATCHDOG_EN
        // Done on the expiry edge takes priority over the timeout
        else if (wd_cnt_q == WD_LAST) begin
          err_d    = 1'b1;
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
`endif
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign PC          = pc_lo;
  assign Halted      = halted_q;
  assign instr_count = cnt_q;
`ifdef SEQ_WATCHDOG_EN
  assign Err         = err_q;
`else
  assign Err         = 1'b0;
`endif

endmodule
